// File: rtl/apb_reg_pkg.sv
// Shared types and constants for the APB register completer and its register bank.
package apb_reg_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_e;

  localparam int ADDR_LSB   = 2;
  localparam int ADDR_IDX_W = 8;

  localparam logic [31:0] DEFAULT_ID = 32'hA9B0_0001;

  // Why a transfer was refused; ERR_NONE means the transfer is accepted.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE,
    ERR_RO_WRITE
  } err_cause_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register storage: strobed write port, read mux with the constant ID at index 0, range check.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_IDX_W-1:0] widx_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic [ADDR_IDX_W-1:0] ridx_i,
  output logic [31:0]           rdata_o,
  output logic                  in_range_o
);

  // Index 0 is the read-only ID, so no storage exists for it.
  logic [31:0] regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx_i == ADDR_IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) regs_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_o = (ridx_i == '0) ? ID_VALUE : '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx_i == ADDR_IDX_W'(i)) rdata_o = regs_q[i];
    end
  end

  assign in_range_o = ({1'b0, ridx_i} < (ADDR_IDX_W + 1)'(NUM_REGS));

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer: decodes and latches each transfer at setup, stretches PREADY by
// WAIT_STATES cycles, then commits strobed writes or returns read data / PSLVERR.
module apb_reg_completer
  import apb_reg_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    pready_q;
  err_cause_e              err_cause_q;
  logic [ADDR_IDX_W-1:0]   idx_q;
  logic [31:0]             rdata_q;

  logic [ADDR_IDX_W-1:0]   idx_d;
  err_cause_e              err_cause_d;
  logic [31:0]             bank_rdata;
  logic                    bank_in_range;
  logic                    bank_we;

  assign idx_d = PADDR[ADDR_LSB +: ADDR_IDX_W];

  always_comb begin
    err_cause_d = ERR_NONE;
    if (PADDR[ADDR_LSB-1:0] != '0)
      err_cause_d = ERR_MISALIGN;
    else if ((PADDR[31:ADDR_LSB+ADDR_IDX_W] != '0) || !bank_in_range)
      err_cause_d = ERR_RANGE;
    else if (PWRITE && (idx_d == '0))
      err_cause_d = ERR_RO_WRITE;
  end

  // Commit uses the index latched at setup; data and strobes are sampled at completion.
  assign bank_we = (state_q == ST_ACCESS) && pready_q && PSEL && PENABLE && PWRITE &&
                   (err_cause_q == ERR_NONE);

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk_i      (clk),
    .rst_i      (PRESET),
    .we_i       (bank_we),
    .widx_i     (idx_q),
    .wdata_i    (PWDATA),
    .wstrb_i    (PSTRB),
    .ridx_i     (idx_d),
    .rdata_o    (bank_rdata),
    .in_range_o (bank_in_range)
  );

  always_ff @(posedge clk) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      err_cause_q <= ERR_NONE;
      idx_q       <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q <= 1'b0;
          // PENABLE without a preceding setup cycle is not a transfer.
          if (PSEL && !PENABLE) begin
            state_q     <= ST_ACCESS;
            cnt_q       <= 4'(WAIT_STATES);
            pready_q    <= (WAIT_STATES == 0);
            err_cause_q <= err_cause_d;
            idx_q       <= idx_d;
            rdata_q     <= (!PWRITE && (err_cause_d == ERR_NONE)) ? bank_rdata : '0;
          end
        end
        ST_ACCESS: begin
          if (!PSEL || pready_q) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            pready_q <= (cnt_q == 4'd1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pready_q && (err_cause_q != ERR_NONE);
  assign PRDATA  = pready_q ? rdata_q : '0;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench: three completers (0, 3 and 5 wait states) on one shared bus, selected by PSEL.
module tb_apb_reg_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk;
  logic        preset;
  logic [31:0] paddr;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  apb_reg_completer #(.NUM_REGS(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_reg_completer #(.NUM_REGS(16), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_reg_completer #(.NUM_REGS(16), .WAIT_STATES(5)) u_dut2 (
    .clk(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    @(negedge clk);
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
  endtask

  // One full transfer on DUT d; returns captured data/error and setup-to-PREADY latency.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] strb,
                          output logic [31:0] rd, output logic er, output int lat);
    int  t0;
    bit  done;
    @(negedge clk);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    t0 = cyc;
    @(negedge clk);
    penable = 1'b1;
    done = 1'b0; rd = '0; er = 1'b0; lat = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (pready[d]) begin
        rd = prdata[d]; er = pslverr[d]; lat = cyc - t0; done = 1'b1;
      end else begin
        chk($sformatf("wait_outputs_zero dut%0d", d), prdata[d] | {31'b0, pslverr[d]}, 32'h0);
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL pready_timeout dut%0d addr %h: got no PREADY expected PREADY within 40 cycles", d, addr);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] b2b_data [3];

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, ID,            1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0014, 32'h0,          4'h0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344,  4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF,  4'h5, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,          4'h0, 32'h11FF_33FF, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h1234_5678,  4'hF, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0040, 32'h1234_5678,  4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0006, 32'h0,          4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, ID,            1'b0};
    vecs[9]  = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D,  4'h0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,          4'h0, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D,  4'hA, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_003C, 32'h0,          4'h0, 32'hCA00_F000, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0400, 32'h0,          4'h0, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 32'h0000_003C, 32'h0,          4'hF, 32'hCA00_F000, 1'b0};
    b2b_data[0] = 32'h0404_A001;
    b2b_data[1] = 32'h0808_B002;
    b2b_data[2] = 32'h0C0C_C003;

    preset = 1'b1;
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_pready dut%0d", d), {31'b0, pready[d]}, 32'h0);
      chk($sformatf("reset_pslverr dut%0d", d), {31'b0, pslverr[d]}, 32'h0);
      chk($sformatf("reset_prdata dut%0d", d), prdata[d], 32'h0);
    end
    preset = 1'b0;

    // Table-driven transfers on the zero-wait-state completer.
    for (int v = 0; v < 15; v++) begin
      apb_xfer(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, er, lat);
      chk($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_pslverr", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd1);
    end
    bus_idle();

    // Three back-to-back writes then readback, zero wait states.
    for (int k = 0; k < 3; k++) begin
      apb_xfer(0, 1'b1, 32'(4 * (k + 1)), b2b_data[k], 4'hF, rd, er, lat);
      chk($sformatf("b2b_wr%0d_latency", k), 32'(lat), 32'd1);
      chk($sformatf("b2b_wr%0d_pslverr", k), {31'b0, er}, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      apb_xfer(0, 1'b0, 32'(4 * (k + 1)), 32'h0, 4'h0, rd, er, lat);
      chk($sformatf("b2b_rd%0d_prdata", k), rd, b2b_data[k]);
    end

    // PENABLE high in IDLE without a setup cycle must not start or commit anything.
    @(negedge clk);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("stray_penable_pready", {31'b0, pready[0]}, 32'h0);
    end
    bus_idle();
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lat);
    chk("stray_penable_no_write", rd, b2b_data[2]);
    bus_idle();

    // Three wait states: write then read 0x14.
    apb_xfer(1, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("ws3_wr_latency", 32'(lat), 32'd4);
    chk("ws3_wr_pslverr", {31'b0, er}, 32'h0);
    apb_xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("ws3_rd_latency", 32'(lat), 32'd4);
    chk("ws3_rd_prdata", rd, 32'hDEAD_BEEF);
    apb_xfer(1, 1'b1, 32'h00, 32'h1, 4'hF, rd, er, lat);
    chk("ws3_ro_pslverr", {31'b0, er}, 32'h1);
    bus_idle();

    // Five wait states: reset in the middle of a write to 0x10.
    apb_xfer(2, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, rd, er, lat);
    chk("ws5_prewrite_latency", 32'(lat), 32'd6);
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("ws5_in_wait_pready", {31'b0, pready[2]}, 32'h0);
    preset = 1'b1;
    @(negedge clk);
    chk("reset_midxfer_pready", {31'b0, pready[2]}, 32'h0);
    chk("reset_midxfer_prdata", prdata[2], 32'h0);
    preset = 1'b0; psel = '0; penable = 1'b0;
    apb_xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("reset_reg10_cleared", rd, 32'h0);
    chk("reset_reg10_pslverr", {31'b0, er}, 32'h0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, lat);
    chk("reset_dut0_reg08_cleared", rd, 32'h0);
    apb_xfer(2, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
    chk("reset_id_intact", rd, ID);
    bus_idle();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
